vscale_hasti_arbiter: RTL and testbench

//  Two-master to one-slave HASTI (AHB-Lite) arbiter sharing one single-port SRAM between core dmem (m0) and imem (m1).

---
 rtl/vscale_hasti_arbiter.sv | 169 ++++++++++++++++
 tb/tb_vscale_hasti_arbiter.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/vscale_hasti_arbiter.sv
// vscale_hasti_arbiter: two-master (m0 = dmem, m1 = imem) to one-slave
// HASTI/AHB-Lite arbiter. Each master has a one-entry address-phase buffer.
// A losing request is captured there, and the master is then stalled in its
// data phase rather than in its address phase.
// Config macro: VSCALE_HASTI_ARB_RR_EN selects round-robin arbitration.
// When it is undefined, m0 always wins (fixed priority).
module vscale_hasti_arbiter #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [ADDR_WIDTH-1:0] m0_haddr,
   input  logic                  m0_hwrite,
   input  logic [2:0]            m0_hsize,
   input  logic [2:0]            m0_hburst,
   input  logic [3:0]            m0_hprot,
   input  logic                  m0_hmastlock,
   input  logic [1:0]            m0_htrans,
   input  logic [DATA_WIDTH-1:0] m0_hwdata,
   output logic [DATA_WIDTH-1:0] m0_hrdata,
   output logic                  m0_hready,
   output logic                  m0_hresp,
   input  logic [ADDR_WIDTH-1:0] m1_haddr,
   input  logic                  m1_hwrite,
   input  logic [2:0]            m1_hsize,
   input  logic [2:0]            m1_hburst,
   input  logic [3:0]            m1_hprot,
   input  logic                  m1_hmastlock,
   input  logic [1:0]            m1_htrans,
   input  logic [DATA_WIDTH-1:0] m1_hwdata,
   output logic [DATA_WIDTH-1:0] m1_hrdata,
   output logic                  m1_hready,
   output logic                  m1_hresp,
   output logic [ADDR_WIDTH-1:0] s_haddr,
   output logic                  s_hwrite,
   output logic [2:0]            s_hsize,
   output logic [2:0]            s_hburst,
   output logic [3:0]            s_hprot,
   output logic                  s_hmastlock,
   output logic [1:0]            s_htrans,
   output logic [DATA_WIDTH-1:0] s_hwdata,
   input  logic [DATA_WIDTH-1:0] s_hrdata,
   input  logic                  s_hready,
   input  logic                  s_hresp
);

   // address-phase bundle: everything a master presents alongside haddr
   typedef struct packed {
      logic [ADDR_WIDTH-1:0] haddr;
      logic                  hwrite;
      logic [2:0]            hsize;
      logic [2:0]            hburst;
      logic [3:0]            hprot;
      logic                  hmastlock;
      logic [1:0]            htrans;
   } ap_t;

   typedef enum logic [1:0] {OWN_NONE, OWN_M0, OWN_M1} owner_e;

   ap_t        m_ap   [2];
   ap_t        buf_ap [2];
   ap_t        src_ap [2];
   ap_t        s_ap, ap_q;
   logic [1:0] buf_vld, live, req, gnt, hready, hresp;
   owner_e     dp_owner;

   assign m_ap[0] = {m0_haddr, m0_hwrite, m0_hsize, m0_hburst, m0_hprot, m0_hmastlock, m0_htrans};
   assign m_ap[1] = {m1_haddr, m1_hwrite, m1_hsize, m1_hburst, m1_hprot, m1_hmastlock, m1_htrans};

   for (genvar i = 0; i < 2; i++) begin : g_m
      localparam owner_e ME = owner_e'(i + 1);

      // data-phase owner follows the slave; a buffered master is stalled
      assign hready[i] = reset ? 1'b1 : (dp_owner == ME) ? s_hready : !buf_vld[i];
      assign hresp[i]  = !reset && (dp_owner == ME) && s_hresp;
      assign live[i]   = m_ap[i].htrans[1] & hready[i];
      assign req[i]    = buf_vld[i] | live[i];
      assign src_ap[i] = buf_vld[i] ? buf_ap[i] : m_ap[i];

      // capture a sampled address phase that was not granted; release on grant
      always_ff @(posedge clk) begin
         if (reset) begin
            buf_vld[i] <= 1'b0;
            buf_ap[i]  <= '0;
         end else if (gnt[i]) begin
            buf_vld[i] <= 1'b0;
         end else if (live[i]) begin
            buf_vld[i] <= 1'b1;
            buf_ap[i]  <= m_ap[i];
         end
      end
   end

`ifdef VSCALE_HASTI_ARB_RR_EN
   logic rr_last;  // 1: m1 was granted last

   // remember the most recent winner for round-robin tie-break
   always_ff @(posedge clk) begin
      if (reset)       rr_last <= 1'b1;
      else if (gnt[0]) rr_last <= 1'b0;
      else if (gnt[1]) rr_last <= 1'b1;
   end
`endif

   // one grant per cycle, only while the slave can accept an address
   always_comb begin
      gnt = 2'b00;
      if (!reset && s_hready) begin
`ifdef VSCALE_HASTI_ARB_RR_EN
         if (req[0] && req[1]) gnt = rr_last ? 2'b01 : 2'b10;
         else                  gnt = req;
`else
         if (req[0])      gnt = 2'b01;
         else if (req[1]) gnt = 2'b10;
`endif
      end
   end

   // slave address phase: hold while stalled, else the winner, else IDLE
   always_comb begin
      s_ap = '0;
      if (!reset) begin
         if (!s_hready)   s_ap = ap_q;
         else if (gnt[0]) s_ap = src_ap[0];
         else if (gnt[1]) s_ap = src_ap[1];
      end
   end

   // last driven address phase, replayed while the slave stalls
   always_ff @(posedge clk) begin
      if (reset) ap_q <= '0;
      else       ap_q <= s_ap;
   end

   // data-phase ownership advances only when the slave completes a beat
   always_ff @(posedge clk) begin
      if (reset)         dp_owner <= OWN_NONE;
      else if (s_hready) dp_owner <= gnt[0] ? OWN_M0 : gnt[1] ? OWN_M1 : OWN_NONE;
   end

   // write data comes from whichever master owns the data phase
   always_comb begin
      s_hwdata = '0;
      if (!reset) begin
         case (dp_owner)
            OWN_M0:  s_hwdata = m0_hwdata;
            OWN_M1:  s_hwdata = m1_hwdata;
            default: s_hwdata = '0;
         endcase
      end
   end

   assign s_haddr     = s_ap.haddr;
   assign s_hwrite    = s_ap.hwrite;
   assign s_hsize     = s_ap.hsize;
   assign s_hburst    = s_ap.hburst;
   assign s_hprot     = s_ap.hprot;
   assign s_hmastlock = s_ap.hmastlock;
   assign s_htrans    = s_ap.htrans;

   assign m0_hrdata = s_hrdata;
   assign m1_hrdata = s_hrdata;
   assign m0_hready = hready[0];
   assign m1_hready = hready[1];
   assign m0_hresp  = hresp[0];
   assign m1_hresp  = hresp[1];

endmodule

// File: tb/tb_vscale_hasti_arbiter.sv
// Directed bench for vscale_hasti_arbiter: reset, single-master, contention,
// streaming under fixed/round-robin priority, wait states and error response.
module tb_vscale_hasti_arbiter;
   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [31:0] m0_haddr = '0, m1_haddr = '0;
   logic        m0_hwrite = 1'b0, m1_hwrite = 1'b0;
   logic [2:0]  m0_hsize = 3'd2, m1_hsize = 3'd2;
   logic [2:0]  m0_hburst = '0, m1_hburst = '0;
   logic [3:0]  m0_hprot = '0, m1_hprot = '0;
   logic        m0_hmastlock = 1'b0, m1_hmastlock = 1'b0;
   logic [1:0]  m0_htrans = '0, m1_htrans = '0;
   logic [31:0] m0_hwdata = '0, m1_hwdata = '0;
   logic [31:0] m0_hrdata, m1_hrdata;
   logic        m0_hready, m1_hready, m0_hresp, m1_hresp;
   logic [31:0] s_haddr, s_hwdata, s_hrdata;
   logic        s_hwrite, s_hmastlock;
   logic [2:0]  s_hsize, s_hburst;
   logic [3:0]  s_hprot;
   logic [1:0]  s_htrans;
   logic        s_hready = 1'b1, s_hresp = 1'b0;

   int total = 0;
   int bad = 0;

   always #5 clk = ~clk;

   vscale_hasti_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
      .clk(clk), .reset(reset),
      .m0_haddr(m0_haddr), .m0_hwrite(m0_hwrite), .m0_hsize(m0_hsize), .m0_hburst(m0_hburst),
      .m0_hprot(m0_hprot), .m0_hmastlock(m0_hmastlock), .m0_htrans(m0_htrans),
      .m0_hwdata(m0_hwdata), .m0_hrdata(m0_hrdata), .m0_hready(m0_hready), .m0_hresp(m0_hresp),
      .m1_haddr(m1_haddr), .m1_hwrite(m1_hwrite), .m1_hsize(m1_hsize), .m1_hburst(m1_hburst),
      .m1_hprot(m1_hprot), .m1_hmastlock(m1_hmastlock), .m1_htrans(m1_htrans),
      .m1_hwdata(m1_hwdata), .m1_hrdata(m1_hrdata), .m1_hready(m1_hready), .m1_hresp(m1_hresp),
      .s_haddr(s_haddr), .s_hwrite(s_hwrite), .s_hsize(s_hsize), .s_hburst(s_hburst),
      .s_hprot(s_hprot), .s_hmastlock(s_hmastlock), .s_htrans(s_htrans),
      .s_hwdata(s_hwdata), .s_hrdata(s_hrdata), .s_hready(s_hready), .s_hresp(s_hresp)
   );

   // toy slave: read data is the bitwise inverse of the data-phase address
   logic [31:0] dph_addr;
   always @(posedge clk) begin
      if (reset)                       dph_addr <= '0;
      else if (s_hready && s_htrans[1]) dph_addr <= s_haddr;
   end
   assign s_hrdata = ~dph_addr;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_all();
      m0_htrans = 2'b00; m1_htrans = 2'b00;
      m0_hwrite = 1'b0;  m1_hwrite = 1'b0;
      m0_hwdata = '0;    m1_hwdata = '0;
      s_hready = 1'b1;   s_hresp = 1'b0;
   endtask

   task automatic do_reset();
      idle_all();
      reset = 1'b1;
      tick(); tick();
      reset = 1'b0;
   endtask

   // two masters streaming 4 reads each; records slave issue order and stalls
   task automatic stream();
      logic [31:0] q[$];
      logic [31:0] exp[8];
      int k0 = 0, k1 = 0, st0 = 0, st1 = 0, mx0 = 0, mx1 = 0;
`ifdef VSCALE_HASTI_ARB_RR_EN
      exp = '{32'h1000, 32'h2000, 32'h1004, 32'h2004, 32'h1008, 32'h2008, 32'h100c, 32'h200c};
`else
      exp = '{32'h1000, 32'h1004, 32'h1008, 32'h100c, 32'h2000, 32'h2004, 32'h2008, 32'h200c};
`endif
      for (int c = 0; c < 12; c++) begin
         m0_htrans = (k0 < 4) ? 2'b10 : 2'b00;
         m0_haddr  = 32'h1000 + 32'(k0 * 4);
         m1_htrans = (k1 < 4) ? 2'b10 : 2'b00;
         m1_haddr  = 32'h2000 + 32'(k1 * 4);
         #1;
         if (s_htrans[1]) q.push_back(s_haddr);
         if (m0_htrans[1]) begin
            if (m0_hready) begin k0++; st0 = 0; end
            else begin st0++; if (st0 > mx0) mx0 = st0; end
         end
         if (m1_htrans[1]) begin
            if (m1_hready) begin k1++; st1 = 0; end
            else begin st1++; if (st1 > mx1) mx1 = st1; end
         end
         tick();
      end
      idle_all();
      chk("stream_count", 32'(q.size()), 32'd8);
      for (int i = 0; i < 8; i++)
         chk($sformatf("stream_order%0d", i), (i < q.size()) ? q[i] : 32'hffff_ffff, exp[i]);
`ifdef VSCALE_HASTI_ARB_RR_EN
      chk("stream_m0_max_stall", 32'(mx0), 32'd1);
      chk("stream_m1_max_stall", 32'(mx1), 32'd1);
`else
      chk("stream_m0_max_stall", 32'(mx0), 32'd0);
      chk("stream_m1_max_stall", 32'(mx1), 32'd4);
`endif
   endtask

   initial begin
      // reset state
      do_reset();
      #1;
      chk("rst_m0_hready", 32'(m0_hready), 32'd1);
      chk("rst_m1_hready", 32'(m1_hready), 32'd1);
      chk("rst_s_htrans",  32'(s_htrans),  32'd0);
      chk("rst_m0_hresp",  32'(m0_hresp),  32'd0);
      chk("rst_s_hwdata",  s_hwdata,       32'd0);
      tick();

      // 1: reset mid-write with a buffered m1 read
      m0_htrans = 2'b10; m0_haddr = 32'h10; m0_hwrite = 1'b1;
      m1_htrans = 2'b10; m1_haddr = 32'h20;
      tick();
      m0_htrans = 2'b00; m1_htrans = 2'b00; m0_hwdata = 32'h1234_5678;
      s_hready = 1'b0;
      #1;
      chk("t1_m0_stall", 32'(m0_hready), 32'd0);
      chk("t1_m1_buf",   32'(m1_hready), 32'd0);
      reset = 1'b1;
      #1;
      chk("t1_rst_m1_hready", 32'(m1_hready), 32'd1);
      chk("t1_rst_s_htrans",  32'(s_htrans),  32'd0);
      tick();
      reset = 1'b0; s_hready = 1'b1;
      #1;
      chk("t1_post_m0_hready", 32'(m0_hready), 32'd1);
      chk("t1_post_m1_hready", 32'(m1_hready), 32'd1);
      chk("t1_post_s_htrans",  32'(s_htrans),  32'd0);
      chk("t1_post_s_hwdata",  s_hwdata,       32'd0);
      tick();

      // 2: lone m0 write, zero-wait
      do_reset();
      m0_htrans = 2'b10; m0_haddr = 32'h100; m0_hwrite = 1'b1;
      #1;
      chk("t2_s_htrans", 32'(s_htrans), 32'd2);
      chk("t2_s_haddr",  s_haddr,       32'h100);
      chk("t2_s_hwrite", 32'(s_hwrite), 32'd1);
      chk("t2_m0_hready_a", 32'(m0_hready), 32'd1);
      tick();
      m0_htrans = 2'b00; m0_hwrite = 1'b0; m0_hwdata = 32'hDEAD_BEEF;
      #1;
      chk("t2_s_hwdata", s_hwdata, 32'hDEAD_BEEF);
      chk("t2_m0_hready_d", 32'(m0_hready), 32'd1);
      chk("t2_s_htrans_idle", 32'(s_htrans), 32'd0);
      tick();
      #1;
      chk("t2_s_hwdata_none", s_hwdata, 32'd0);

      // 3: simultaneous reads, m0 first, m1 from buffer
      do_reset();
      m0_htrans = 2'b10; m0_haddr = 32'h200;
      m1_htrans = 2'b10; m1_haddr = 32'h400;
      #1;
      chk("t3_first_addr", s_haddr, 32'h200);
      tick();
      m0_htrans = 2'b00; m1_htrans = 2'b00;
      #1;
      chk("t3_buf_addr",    s_haddr,        32'h400);
      chk("t3_buf_htrans",  32'(s_htrans),  32'd2);
      chk("t3_m1_stall",    32'(m1_hready), 32'd0);
      chk("t3_m0_done",     32'(m0_hready), 32'd1);
      chk("t3_m0_hrdata",   m0_hrdata,      ~32'h200);
      tick();
      #1;
      chk("t3_m1_done",     32'(m1_hready), 32'd1);
      chk("t3_m1_hrdata",   m1_hrdata,      ~32'h400);
      chk("t3_idle",        32'(s_htrans),  32'd0);
      tick();

      // 4/5: streaming contention
      do_reset();
      stream();

      // 6: wait states then two-cycle error on an m1 write
      do_reset();
      m1_htrans = 2'b10; m1_haddr = 32'h300; m1_hwrite = 1'b1;
      #1;
      chk("t6_issue", 32'(s_htrans), 32'd2);
      tick();
      m1_htrans = 2'b00; m1_hwrite = 1'b0;
      m0_htrans = 2'b10; m0_haddr = 32'h500;
      s_hready = 1'b0;
      #1;
      chk("t6_w1_m1_hready", 32'(m1_hready), 32'd0);
      chk("t6_w1_m1_hresp",  32'(m1_hresp),  32'd0);
      chk("t6_w1_hold_addr", s_haddr,        32'h300);
      chk("t6_w1_hold_wr",   32'(s_hwrite),  32'd1);
      tick();
      m0_htrans = 2'b00;
      #1;
      chk("t6_w2_m1_hready", 32'(m1_hready), 32'd0);
      chk("t6_w2_m0_buf",    32'(m0_hready), 32'd0);
      chk("t6_w2_hold_addr", s_haddr,        32'h300);
      tick();
      s_hresp = 1'b1;
      #1;
      chk("t6_e1_m1_hready", 32'(m1_hready), 32'd0);
      chk("t6_e1_m1_hresp",  32'(m1_hresp),  32'd1);
      chk("t6_e1_m0_hresp",  32'(m0_hresp),  32'd0);
      tick();
      s_hready = 1'b1;
      #1;
      chk("t6_e2_m1_hready", 32'(m1_hready), 32'd1);
      chk("t6_e2_m1_hresp",  32'(m1_hresp),  32'd1);
      chk("t6_e2_m0_hresp",  32'(m0_hresp),  32'd0);
      chk("t6_e2_m0_addr",   s_haddr,        32'h500);
      tick();
      s_hresp = 1'b0;
      #1;
      chk("t6_m0_done",   32'(m0_hready), 32'd1);
      chk("t6_m1_hresp0", 32'(m1_hresp),  32'd0);
      tick();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
